// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the round-robin scan controller.
// Holds the state encoding, channel indices and the mux select table.
package mux_scan_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   typedef struct packed {
      logic sel1;
      logic sel2;
      logic sel3;
   } sel_t;

   // Selects that no level of the mux tree looks at are driven 0.
   function automatic sel_t sel_of(logic [1:0] ch);
      sel_t s;
      s = '0;
      unique case (ch)
         CH_A: s = '{sel1: 1'b1, sel2: 1'b0, sel3: 1'b1};
         CH_B: s = '{sel1: 1'b0, sel2: 1'b0, sel3: 1'b1};
         CH_C: s = '{sel1: 1'b0, sel2: 1'b1, sel3: 1'b0};
         CH_D: s = '{sel1: 1'b0, sel2: 1'b0, sel3: 1'b0};
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] onehot(logic [1:0] ch);
      return 4'b0001 << ch;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Channel inputs and output stream of the scan controller.
// master = controller side, slave = source/consumer side.
interface mux_scan_ctrl_if;

   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] c;
   logic [7:0] d;
   logic [3:0] req;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic [3:0] grant;
   logic [1:0] cur_ch;
   logic [7:0] xfer_cnt;

   modport master (
      input  a, b, c, d, req, out_ready,
      output out_data, out_valid, grant, cur_ch, xfer_cnt
   );

   modport slave (
      output a, b, c, d, req, out_ready,
      input  out_data, out_valid, grant, cur_ch, xfer_cnt
   );

endinterface

// File: rtl/mux_scan_ctrl_mux.sv
// Two-level 4:1 byte mux: sel1 picks a/b, sel2 picks c/d,
// sel3 picks between the two pairs.
module Mux_8bits (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   input  logic       sel1,
   input  logic       sel2,
   input  logic       sel3,
   output logic [7:0] f
);

   logic [7:0] ab;
   logic [7:0] cd;

   assign ab = sel1 ? a : b;
   assign cd = sel2 ? c : d;
   assign f  = sel3 ? ab : cd;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin 4-channel byte scanner with a valid/ready output
// stage and a count of completed handshakes.
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   mux_scan_ctrl_if.master  bus
);

   state_t     state;
   state_t     nxt;
   logic [1:0] last;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       hit;
   logic       capture;
   logic       done;
   sel_t       sel;
   logic [7:0] f;

   // Search upward from last+1 so the previous winner goes last.
   always_comb begin
      winner = last;
      hit    = 1'b0;
      idx    = last;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!hit && bus.req[idx]) begin
            winner = idx;
            hit    = 1'b1;
         end
      end
   end

   assign sel = sel_of(winner);

   Mux_8bits u_mux (
      .a    (bus.a),
      .b    (bus.b),
      .c    (bus.c),
      .d    (bus.d),
      .sel1 (sel.sel1),
      .sel2 (sel.sel2),
      .sel3 (sel.sel3),
      .f    (f)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = hit ? SEND : IDLE;
         SEND:    nxt = bus.out_ready ? IDLE : SEND;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE:    capture = hit;
         SEND:    done    = bus.out_ready;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_data  <= 8'h00;
         bus.out_valid <= 1'b0;
         bus.grant     <= 4'b0000;
         bus.cur_ch    <= CH_A;
         bus.xfer_cnt  <= 8'h00;
         last          <= CH_D;
      end else begin
         bus.grant <= 4'b0000;
         if (capture) begin
            bus.out_data  <= f;
            bus.out_valid <= 1'b1;
            bus.cur_ch    <= winner;
            bus.grant     <= onehot(winner);
         end
         if (done) begin
            bus.out_valid <= 1'b0;
            bus.xfer_cnt  <= bus.xfer_cnt + 8'd1;
            last          <= bus.cur_ch;
         end
      end
   end

endmodule
